sync_fifo_flags: RTL and testbench

//   Parametrised single-clock FIFO, successor to the basic synchronous FIFO.

---
 rtl/sync_fifo_flags.sv | 179 +++++++++++++++++
 tb/tb_sync_fifo_flags.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy count, programmable
// almost-full / almost-empty flags and an optional first-word-fall-through read.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   wr_en, din          write request and data
//   rd_en, dout         read request and data
//   full, empty         registered, derived from the stored count only
//   almost_full         count >= AFULL_TH
//   almost_empty        count <= AEMPTY_TH
//   count               stored entries, 0..DEPTH
//   overflow, underflow sticky error flags       (SYNC_FIFO_ERR_FLAGS_EN only)
//   err_clr             clears the sticky flags  (SYNC_FIFO_ERR_FLAGS_EN only)
//
// Build option: define SYNC_FIFO_ERR_FLAGS_EN to add the sticky error flags.
// FWFT = 0 gives a registered read (dout valid one cycle after rd_en);
// FWFT = 1 presents the head word on dout whenever the FIFO is not empty.
module sync_fifo_flags #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 6,
  parameter int unsigned AFULL_TH   = 56,
  parameter int unsigned AEMPTY_TH  = 8,
  parameter int unsigned FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      din,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [DEPTH_LOG2:0]   count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;

  localparam logic [PW-1:0] DepthCnt  = PW'(DEPTH);
  localparam logic [PW-1:0] AfullCnt  = PW'(AFULL_TH);
  localparam logic [PW-1:0] AemptyCnt = PW'(AEMPTY_TH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          rd_acc, wr_acc;

  logic [DEPTH_LOG2-1:0] wr_addr, rd_addr;

  // The MSB of each pointer is a wrap bit; only the low bits address storage.
  assign wr_addr = wr_ptr_q[DEPTH_LOG2-1:0];
  assign rd_addr = rd_ptr_q[DEPTH_LOG2-1:0];

  always_comb begin
    rd_acc = rd_en & ~empty_q;
    // When full, a write is only taken alongside a read that frees a slot.
    wr_acc = wr_en & (~full_q | rd_acc);

    wr_ptr_d = wr_ptr_q + PW'(wr_acc);
    rd_ptr_d = rd_ptr_q + PW'(rd_acc);

    count_d = count_q;
    if (wr_acc && !rd_acc) begin
      count_d = count_q + PW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - PW'(1);
    end

    // All flags come from the next count so they land together with it.
    full_d   = (count_d == DepthCnt);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AfullCnt);
    aempty_d = (count_d <= AemptyCnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_addr] <= din;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Gate to zero while empty so dout reads 0 out of reset.
      assign dout = empty_q ? '0 : mem_q[rd_addr];
    end else begin : g_reg_read
      logic [WIDTH-1:0] dout_q, dout_d;

      always_comb begin
        dout_d = dout_q;
        if (rd_acc) begin
          dout_d = mem_q[rd_addr];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q <= '0;
        end else begin
          dout_q <= dout_d;
        end
      end

      assign dout = dout_q;
    end
  endgenerate

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // A set event in the same cycle as err_clr wins over the clear.
  always_comb begin
    overflow_d  = overflow_q & ~err_clr;
    underflow_d = underflow_q & ~err_clr;
    if (wr_en && !wr_acc) begin
      overflow_d = 1'b1;
    end
    if (rd_en && empty_q) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags: one registered-read instance driven
// through a queue-based reference model, plus a small FWFT instance.
module tb_sync_fifo_flags;

  localparam int W     = 8;
  localparam int DL    = 6;
  localparam int DEPTH = 64;
  localparam int AF    = 56;
  localparam int AE    = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         wr_en, rd_en;
  logic [W-1:0] din, dout;
  logic         full, empty, almost_full, almost_empty;
  logic [DL:0]  count;

  logic         f_wr_en, f_rd_en;
  logic [W-1:0] f_din, f_dout;
  logic         f_full, f_empty, f_almost_full, f_almost_empty;
  logic [DL:0]  f_count;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic err_clr;
  logic overflow, underflow, f_overflow, f_underflow;
`endif

  sync_fifo_flags #(
    .WIDTH(W), .DEPTH_LOG2(DL), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
`endif
  );

  sync_fifo_flags #(
    .WIDTH(W), .DEPTH_LOG2(DL), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1)
  ) u_dut_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(f_wr_en), .din(f_din), .rd_en(f_rd_en),
    .dout(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_almost_full),
    .almost_empty(f_almost_empty), .count(f_count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , .overflow(f_overflow), .underflow(f_underflow), .err_clr(err_clr)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of stored words plus last registered read value.
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_dout;
  int           m_count;
  int           m_pushes;
  bit           m_ovf, m_unf;

  typedef struct {
    bit           w;
    logic [W-1:0] d;
    bit           r;
    int           e_count;
    bit           e_empty;
    logic [W-1:0] e_dout;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_dout  = '0;
    m_count = 0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  // One clock of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic drive(input bit w, input logic [W-1:0] d, input bit r, input bit clr);
    bit racc, wacc;
    racc = r && (m_count != 0);
    wacc = w && ((m_count != DEPTH) || racc);
    wr_en = w;
    din   = d;
    rd_en = r;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    err_clr = clr;
`endif
    @(posedge clk);
    #1;
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (w && !wacc) m_ovf = 1'b1;
    if (r && m_count == 0) m_unf = 1'b1;
    if (racc) m_dout = m_q.pop_front();
    if (wacc) begin
      m_q.push_back(d);
      m_pushes++;
    end
    m_count = m_q.size();
    wr_en = 1'b0;
    rd_en = 1'b0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    err_clr = 1'b0;
`endif
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(m_count));
    chk({tag, ".empty"}, 32'(empty), 32'(m_count == 0));
    chk({tag, ".full"}, 32'(full), 32'(m_count == DEPTH));
    chk({tag, ".afull"}, 32'(almost_full), 32'(m_count >= AF));
    chk({tag, ".aempty"}, 32'(almost_empty), 32'(m_count <= AE));
    chk({tag, ".dout"}, 32'(dout), 32'(m_dout));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
`endif
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    din     = '0;
    f_wr_en = 1'b0;
    f_rd_en = 1'b0;
    f_din   = '0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    err_clr = 1'b0;
`endif
    model_clear();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int writes;
    int cyc;

    vt[0] = '{w: 1, d: 8'hA1, r: 0, e_count: 1, e_empty: 0, e_dout: 8'h00};
    vt[1] = '{w: 1, d: 8'hB2, r: 0, e_count: 2, e_empty: 0, e_dout: 8'h00};
    vt[2] = '{w: 1, d: 8'hC3, r: 1, e_count: 2, e_empty: 0, e_dout: 8'hA1};
    vt[3] = '{w: 0, d: 8'h00, r: 1, e_count: 1, e_empty: 0, e_dout: 8'hB2};
    vt[4] = '{w: 0, d: 8'h00, r: 1, e_count: 0, e_empty: 1, e_dout: 8'hC3};
    vt[5] = '{w: 0, d: 8'h00, r: 1, e_count: 0, e_empty: 1, e_dout: 8'hC3};
    vt[6] = '{w: 1, d: 8'hA5, r: 1, e_count: 1, e_empty: 0, e_dout: 8'hC3};
    vt[7] = '{w: 0, d: 8'h00, r: 1, e_count: 0, e_empty: 1, e_dout: 8'hA5};

    m_pushes = 0;
    do_reset();
    @(posedge clk);
    #1;
    chk("rst.count", 32'(count), 0);
    chk("rst.empty", 32'(empty), 1);
    chk("rst.full", 32'(full), 0);
    chk("rst.afull", 32'(almost_full), 0);
    chk("rst.aempty", 32'(almost_empty), 1);
    chk("rst.dout", 32'(dout), 0);
    chk("rst.f_dout", 32'(f_dout), 0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("rst.ovf", 32'(overflow), 0);
    chk("rst.unf", 32'(underflow), 0);
`endif

    // Short table of single-cycle transactions, including reads on empty and
    // a simultaneous write/read into an empty FIFO.
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].w, vt[i].d, vt[i].r, 1'b0);
      chk($sformatf("vec%0d.count", i), 32'(count), 32'(vt[i].e_count));
      chk($sformatf("vec%0d.empty", i), 32'(empty), 32'(vt[i].e_empty));
      chk($sformatf("vec%0d.dout", i), 32'(dout), 32'(vt[i].e_dout));
      check_all($sformatf("vec%0d", i));
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("unf.sticky", 32'(underflow), 1);
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("unf.clr", 32'(underflow), 0);
    drive(1'b0, '0, 1'b1, 1'b1);
    chk("unf.set_wins", 32'(underflow), 1);
    check_all("errclr");
    drive(1'b0, '0, 1'b0, 1'b1);
`endif

    // Fill 0x00..0x3F.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, W'(i), 1'b0, 1'b0);
      check_all($sformatf("fill%0d", i));
    end
    chk("fill.full", 32'(full), 1);
    chk("fill.count", 32'(count), 64);
    chk("fill.afull", 32'(almost_full), 1);

    // Drain; each word appears one cycle after its rd_en.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      chk($sformatf("drain%0d.dout", i), 32'(dout), 32'(i));
      check_all($sformatf("drain%0d", i));
    end
    chk("drain.empty", 32'(empty), 1);
    chk("drain.aempty", 32'(almost_empty), 1);

    // Full FIFO with simultaneous write and read for 10 cycles.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, W'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, W'(8'h80 + i), 1'b1, 1'b0);
      chk($sformatf("wrrd%0d.count", i), 32'(count), 64);
      chk($sformatf("wrrd%0d.full", i), 32'(full), 1);
      check_all($sformatf("wrrd%0d", i));
    end
    // Write alone while full is dropped.
    drive(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("ovf.count", 32'(count), 64);
    check_all("ovf");
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("ovf.flag", 32'(overflow), 1);
    drive(1'b0, '0, 1'b0, 1'b1);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      check_all($sformatf("drain2_%0d", i));
    end
    chk("drain2.last", 32'(dout), 32'h89);

    // FWFT instance: head word appears without a read.
    do_reset();
    f_wr_en = 1'b1;
    f_din   = 8'h5A;
    @(posedge clk);
    #1;
    f_wr_en = 1'b0;
    chk("fwft.empty", 32'(f_empty), 0);
    chk("fwft.dout", 32'(f_dout), 32'h5A);
    chk("fwft.count", 32'(f_count), 1);
    f_wr_en = 1'b1;
    f_din   = 8'h22;
    @(posedge clk);
    #1;
    f_wr_en = 1'b0;
    chk("fwft.hold", 32'(f_dout), 32'h5A);
    f_rd_en = 1'b1;
    @(posedge clk);
    #1;
    chk("fwft.next", 32'(f_dout), 32'h22);
    chk("fwft.count2", 32'(f_count), 1);
    @(posedge clk);
    #1;
    f_rd_en = 1'b0;
    chk("fwft.empty2", 32'(f_empty), 1);
    chk("fwft.count3", 32'(f_count), 0);

    // Reset in the middle of a burst at count 30.
    do_reset();
    for (int i = 0; i < 31; i++) drive(1'b1, W'(8'h10 + i), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("mid.count", 32'(count), 30);
    chk("mid.dout", 32'(dout), 32'h10);
    wr_en = 1'b1;
    din   = 8'h77;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.count", 32'(count), 0);
    chk("midrst.empty", 32'(empty), 1);
    chk("midrst.dout", 32'(dout), 0);
    chk("midrst.full", 32'(full), 0);
    wr_en = 1'b0;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic past the pointer wrap, checked against the model.
    m_pushes = 0;
    writes   = 0;
    for (cyc = 0; cyc < 2000 && writes < 100; cyc++) begin
      drive(($urandom % 4) != 0, W'($urandom), ($urandom % 2) != 0, 1'b0);
      check_all($sformatf("rnd%0d", cyc));
      writes = m_pushes;
    end
    chk("rnd.writes", 32'(writes), 100);
    for (cyc = 0; cyc < 200 && m_count != 0; cyc++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      check_all($sformatf("rnddrain%0d", cyc));
    end
    chk("rnd.empty", 32'(empty), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
